// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared opcodes, state encodings and IR field positions for ALU, datapath and control
package cpu_defs;

  localparam int OPC_W   = 5;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  // Ra/Rb/Rc occupy IR[26:15]; the datapath decodes them, control only selects which one
  localparam int IR_REG_MSB = 26;
  localparam int IR_REG_LSB = 15;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_t;

  typedef struct packed {
    logic three_op;
    logic two_op;
    logic muldiv;
    logic nop;
    logic halt;
    logic illegal;
  } op_class_t;

  // Registered control word; pcin_arm is qualified by Mem_rdy at the port
  typedef struct packed {
    logic run;
    logic pcout;
    logic zlowout;
    logic zhighout;
    logic mdrout;
    logic hiout;
    logic loout;
    logic marin;
    logic pcin_arm;
    logic mdrin;
    logic irin;
    logic yin;
    logic zlowin;
    logic zhighin;
    logic hiin;
    logic loin;
    logic incpc;
    logic read;
    logic gra;
    logic grb;
    logic grc;
    logic rin;
    logic rout;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/op_class_decode.sv
// rtl/op_class_decode.sv - combinational opcode to instruction-class decode
module op_class_decode
  import cpu_defs::*;
(
  input  logic [OPC_W-1:0] opcode,
  output op_class_t        cls
);

  // One class bit per opcode; anything not listed is illegal
  always_comb begin
    cls = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls.three_op = 1'b1;
      OP_NEG, OP_NOT:                 cls.two_op   = 1'b1;
      OP_MUL, OP_DIV:                 cls.muldiv   = 1'b1;
      OP_NOP:                         cls.nop      = 1'b1;
      OP_HALT:                        cls.halt     = 1'b1;
      default:                        cls.illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// rtl/alu_control_sequencer.sv - hardwired fetch/ALU-execute control FSM with registered strobes
module alu_control_sequencer
  import cpu_defs::*;
#(
  parameter int OPW      = 5,
  parameter int RSELW    = 4,
  parameter int PC_RESET = 0
) (
  input  logic            Clock,
  input  logic            Clear,
  input  logic            Start,
  input  logic            Stop,
  input  logic            Mem_rdy,
  input  logic [31:0]     IR,
  output logic            Run,
  output logic            PCout,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            MDRout,
  output logic            HIout,
  output logic            LOout,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            ZLowIn,
  output logic            ZHighIn,
  output logic            HIin,
  output logic            LOin,
  output logic            IncPC,
  output logic            Read,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic [OPW-1:0]  op_code,
  output logic            Illegal
);

  state_t            state_q, state_n;
  op_class_t         cls_d, cls_q;
  ctrl_t             ctrl_q, ctrl_n;
  logic [OPC_W-1:0]  opc_q;
  logic              stop_q;
  logic              stop_now;
  logic              unused_fields;

  // Register fields and informational parameters are not consumed by control
  assign unused_fields = ^{IR[IR_REG_MSB:0], 32'(PC_RESET), 32'(RSELW)};

  op_class_decode u_dec (
    .opcode (IR[OPC_MSB:OPC_LSB]),
    .cls    (cls_d)
  );

  // A Stop seen this cycle counts as much as one latched earlier
  assign stop_now = stop_q | Stop;

  // Next-state: one instruction per pass, Stop only honoured at instruction end
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (Start) state_n = ST_T0;
      ST_T0:   state_n = ST_T1;
      ST_T1:   if (Mem_rdy) state_n = ST_T2;
      ST_T2:   state_n = ST_T3;
      ST_T3: begin
        if (cls_q.halt || cls_q.illegal) state_n = ST_HALT;
        else if (cls_q.nop)              state_n = stop_now ? ST_HALT : ST_T0;
        else                             state_n = ST_T4;
      end
      ST_T4:   state_n = ST_T5;
      ST_T5: begin
        if (cls_q.muldiv) state_n = ST_T6;
        else              state_n = stop_now ? ST_HALT : ST_T0;
      end
      ST_T6:   state_n = stop_now ? ST_HALT : ST_T0;
      ST_HALT: if (Start && !Stop) state_n = ST_T0;
      default: state_n = ST_IDLE;
    endcase
  end

  // Control word for the state being entered, so outputs are registered with the state
  always_comb begin
    ctrl_n     = '0;
    ctrl_n.run = (state_n != ST_IDLE) && (state_n != ST_HALT);
    case (state_n)
      ST_T0: begin
        ctrl_n.pcout  = 1'b1;
        ctrl_n.marin  = 1'b1;
        ctrl_n.incpc  = 1'b1;
        ctrl_n.zlowin = 1'b1;
      end
      ST_T1: begin
        ctrl_n.zlowout  = 1'b1;
        ctrl_n.pcin_arm = 1'b1;
        ctrl_n.read     = 1'b1;
        ctrl_n.mdrin    = 1'b1;
      end
      ST_T2: begin
        ctrl_n.mdrout = 1'b1;
        ctrl_n.irin   = 1'b1;
      end
      ST_T3: begin
        ctrl_n.grb     = 1'b1;
        ctrl_n.rout    = 1'b1;
        ctrl_n.yin     = 1'b1;
        ctrl_n.illegal = cls_d.illegal;
      end
      ST_T4: begin
        ctrl_n.rout    = 1'b1;
        ctrl_n.zlowin  = 1'b1;
        ctrl_n.grb     = cls_q.two_op;
        ctrl_n.grc     = cls_q.three_op | cls_q.muldiv;
        ctrl_n.zhighin = cls_q.muldiv;
      end
      ST_T5: begin
        ctrl_n.zlowout = 1'b1;
        ctrl_n.loin    = cls_q.muldiv;
        ctrl_n.gra     = ~cls_q.muldiv;
        ctrl_n.rin     = ~cls_q.muldiv;
      end
      ST_T6: begin
        ctrl_n.zhighout = 1'b1;
        ctrl_n.hiin     = 1'b1;
      end
      default: ctrl_n = ctrl_n;
    endcase
  end

  // State, control word, latched opcode/class and sticky Stop
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
      cls_q   <= '0;
      opc_q   <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      ctrl_q  <= ctrl_n;
      if (state_n == ST_T3) begin
        cls_q <= cls_d;
        opc_q <= IR[OPC_MSB:OPC_LSB];
      end else if ((state_n == ST_T0) || (state_n == ST_IDLE) || (state_n == ST_HALT)) begin
        opc_q <= '0;
      end
      if (state_n == ST_HALT) stop_q <= 1'b0;
      else if (Stop)          stop_q <= 1'b1;
    end
  end

  assign Run      = ctrl_q.run;
  assign PCout    = ctrl_q.pcout;
  assign Zlowout  = ctrl_q.zlowout;
  assign Zhighout = ctrl_q.zhighout;
  assign MDRout   = ctrl_q.mdrout;
  assign HIout    = ctrl_q.hiout;
  assign LOout    = ctrl_q.loout;
  assign MARin    = ctrl_q.marin;
  // PC is reloaded only on the T1 cycle that completes the fetch
  assign PCin     = ctrl_q.pcin_arm & Mem_rdy;
  assign MDRin    = ctrl_q.mdrin;
  assign IRin     = ctrl_q.irin;
  assign Yin      = ctrl_q.yin;
  assign ZLowIn   = ctrl_q.zlowin;
  assign ZHighIn  = ctrl_q.zhighin;
  assign HIin     = ctrl_q.hiin;
  assign LOin     = ctrl_q.loin;
  assign IncPC    = ctrl_q.incpc;
  assign Read     = ctrl_q.read;
  assign Gra      = ctrl_q.gra;
  assign Grb      = ctrl_q.grb;
  assign Grc      = ctrl_q.grc;
  assign Rin      = ctrl_q.rin;
  assign Rout     = ctrl_q.rout;
  assign Illegal  = ctrl_q.illegal;
  assign op_code  = OPW'(opc_q);

endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb/tb_alu_control_sequencer.sv - directed-vector bench for the ALU control sequencer
module tb_alu_control_sequencer;

  logic        Clock, Clear, Start, Stop, Mem_rdy;
  logic [31:0] IR;
  logic        Run, PCout, Zlowout, Zhighout, MDRout, HIout, LOout;
  logic        MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin;
  logic        IncPC, Read, Gra, Grb, Grc, Rin, Rout, Illegal;
  logic [4:0]  op_code;

  int vectors = 0;
  int miscompares = 0;

  alu_control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .Start(Start), .Stop(Stop), .Mem_rdy(Mem_rdy), .IR(IR),
    .Run(Run), .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin), .IncPC(IncPC),
    .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .op_code(op_code), .Illegal(Illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [23:0] obs;
  assign obs = {Run, PCout, Zlowout, Zhighout, MDRout, HIout, LOout, MARin, PCin, MDRin,
                IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin,
                Rout, Illegal};

  localparam logic [23:0] B_RUN = 24'd1 << 23, B_PCOUT = 24'd1 << 22, B_ZLOUT = 24'd1 << 21;
  localparam logic [23:0] B_ZHOUT = 24'd1 << 20, B_MDROUT = 24'd1 << 19;
  localparam logic [23:0] B_MARIN = 24'd1 << 16, B_PCIN = 24'd1 << 15, B_MDRIN = 24'd1 << 14;
  localparam logic [23:0] B_IRIN = 24'd1 << 13, B_YIN = 24'd1 << 12, B_ZLIN = 24'd1 << 11;
  localparam logic [23:0] B_ZHIN = 24'd1 << 10, B_HIIN = 24'd1 << 9, B_LOIN = 24'd1 << 8;
  localparam logic [23:0] B_INCPC = 24'd1 << 7, B_READ = 24'd1 << 6, B_GRA = 24'd1 << 5;
  localparam logic [23:0] B_GRB = 24'd1 << 4, B_GRC = 24'd1 << 3, B_RIN = 24'd1 << 2;
  localparam logic [23:0] B_ROUT = 24'd1 << 1, B_ILL = 24'd1;

  localparam logic [23:0] E_OFF  = 24'd0;
  localparam logic [23:0] E_T0   = B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZLIN;
  localparam logic [23:0] E_T1X  = B_RUN | B_ZLOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [23:0] E_T1S  = B_RUN | B_ZLOUT | B_READ | B_MDRIN;
  localparam logic [23:0] E_T2   = B_RUN | B_MDROUT | B_IRIN;
  localparam logic [23:0] E_T3   = B_RUN | B_GRB | B_ROUT | B_YIN;
  localparam logic [23:0] E_T3I  = E_T3 | B_ILL;
  localparam logic [23:0] E_T43  = B_RUN | B_GRC | B_ROUT | B_ZLIN;
  localparam logic [23:0] E_T42  = B_RUN | B_GRB | B_ROUT | B_ZLIN;
  localparam logic [23:0] E_T4M  = B_RUN | B_GRC | B_ROUT | B_ZLIN | B_ZHIN;
  localparam logic [23:0] E_T53  = B_RUN | B_ZLOUT | B_GRA | B_RIN;
  localparam logic [23:0] E_T5M  = B_RUN | B_ZLOUT | B_LOIN;
  localparam logic [23:0] E_T6   = B_RUN | B_ZHOUT | B_HIIN;

  // Returns to IDLE with all inputs quiet; leaves time at posedge+2
  task automatic do_clear();
    Clear = 1'b1; Start = 1'b0; Stop = 1'b0; Mem_rdy = 1'b1;
    @(posedge Clock); #1;
    Clear = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    Clear = 1'b1; Start = 1'b1; Stop = 1'b0; Mem_rdy = 1'b1; IR = 32'h1800_0000;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clock); #2;
      vectors++;
      if ({obs, op_code} !== {E_OFF, 5'd0}) begin
        miscompares++;
        $display("FAIL reset cyc%0d got %h want %h", i, {obs, op_code}, {E_OFF, 5'd0});
      end
    end
  endtask

  task automatic test_add();
    logic [28:0] ev [7];
    ev = '{{E_T0, 5'd0}, {E_T1X, 5'd0}, {E_T2, 5'd0}, {E_T3, 5'd3},
           {E_T43, 5'd3}, {E_T53, 5'd3}, {E_T0, 5'd0}};
    do_clear();
    IR = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
    Start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge Clock); #2;
      vectors++;
      if ({obs, op_code} !== ev[i]) begin
        miscompares++;
        $display("FAIL add cyc%0d got %h want %h", i, {obs, op_code}, ev[i]);
      end
    end
  endtask

  task automatic test_fetch_stall();
    logic [28:0] ev [10];
    logic        mr [10];
    ev = '{{E_T0, 5'd0}, {E_T1S, 5'd0}, {E_T1S, 5'd0}, {E_T1S, 5'd0}, {E_T1X, 5'd0},
           {E_T2, 5'd0}, {E_T3, 5'd3}, {E_T43, 5'd3}, {E_T53, 5'd3}, {E_T0, 5'd0}};
    mr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_clear();
    IR = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
    Start = 1'b1; Mem_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clock); #1;
      Mem_rdy = mr[i];
      #1;
      vectors++;
      if ({obs, op_code} !== ev[i]) begin
        miscompares++;
        $display("FAIL stall cyc%0d got %h want %h", i, {obs, op_code}, ev[i]);
      end
    end
  endtask

  task automatic test_muldiv();
    logic [28:0] ev [8];
    ev = '{{E_T0, 5'd0}, {E_T1X, 5'd0}, {E_T2, 5'd0}, {E_T3, 5'd15},
           {E_T4M, 5'd15}, {E_T5M, 5'd15}, {E_T6, 5'd15}, {E_T0, 5'd0}};
    do_clear();
    IR = {5'b01111, 4'd0, 4'd4, 4'd5, 15'd0};
    Start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clock); #2;
      vectors++;
      if ({obs, op_code} !== ev[i]) begin
        miscompares++;
        $display("FAIL mul cyc%0d got %h want %h", i, {obs, op_code}, ev[i]);
      end
    end
  endtask

  task automatic test_two_op();
    logic [28:0] ev [7];
    ev = '{{E_T0, 5'd0}, {E_T1X, 5'd0}, {E_T2, 5'd0}, {E_T3, 5'd17},
           {E_T42, 5'd17}, {E_T53, 5'd17}, {E_T0, 5'd0}};
    do_clear();
    IR = {5'b10001, 4'd6, 4'd7, 4'd0, 15'd0};
    Start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge Clock); #2;
      vectors++;
      if ({obs, op_code} !== ev[i]) begin
        miscompares++;
        $display("FAIL neg cyc%0d got %h want %h", i, {obs, op_code}, ev[i]);
      end
    end
  endtask

  task automatic test_nop();
    logic [28:0] ev [6];
    ev = '{{E_T0, 5'd0}, {E_T1X, 5'd0}, {E_T2, 5'd0}, {E_T3, 5'd26},
           {E_T0, 5'd0}, {E_T1X, 5'd0}};
    do_clear();
    IR = {5'b11010, 27'd0};
    Start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clock); #2;
      vectors++;
      if ({obs, op_code} !== ev[i]) begin
        miscompares++;
        $display("FAIL nop cyc%0d got %h want %h", i, {obs, op_code}, ev[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [28:0] ev [6];
    ev = '{{E_T0, 5'd0}, {E_T1X, 5'd0}, {E_T2, 5'd0}, {E_T3I, 5'd31},
           {E_OFF, 5'd0}, {E_OFF, 5'd0}};
    do_clear();
    IR = {5'b11111, 27'd0};
    Start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clock); #1;
      Start = 1'b0;
      #1;
      vectors++;
      if ({obs, op_code} !== ev[i]) begin
        miscompares++;
        $display("FAIL illegal cyc%0d got %h want %h", i, {obs, op_code}, ev[i]);
      end
    end
  endtask

  task automatic test_stop_halt();
    logic [28:0] ev [10];
    logic        st [10];
    logic        sp [10];
    ev = '{{E_T0, 5'd0}, {E_T1X, 5'd0}, {E_T2, 5'd0}, {E_T3, 5'd4}, {E_T43, 5'd4},
           {E_T53, 5'd4}, {E_OFF, 5'd0}, {E_OFF, 5'd0}, {E_OFF, 5'd0}, {E_T0, 5'd0}};
    st = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    sp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_clear();
    IR = {5'b00100, 4'd1, 4'd2, 4'd3, 15'd0};
    Start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clock); #1;
      Start = st[i];
      Stop  = sp[i];
      #1;
      vectors++;
      if ({obs, op_code} !== ev[i]) begin
        miscompares++;
        $display("FAIL stop cyc%0d got %h want %h", i, {obs, op_code}, ev[i]);
      end
    end
  endtask

  task automatic test_clear_midrun();
    do_clear();
    IR = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
    Start = 1'b1;
    repeat (5) @(posedge Clock);
    #2;
    vectors++;
    if ({obs, op_code} !== {E_T43, 5'd3}) begin
      miscompares++;
      $display("FAIL clr_t4 got %h want %h", {obs, op_code}, {E_T43, 5'd3});
    end
    Clear = 1'b1;
    #1;
    vectors++;
    if ({obs, op_code} !== {E_OFF, 5'd0}) begin
      miscompares++;
      $display("FAIL clr_async got %h want %h", {obs, op_code}, {E_OFF, 5'd0});
    end
    @(posedge Clock); #1;
    Clear = 1'b0; Start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clock); #2;
      vectors++;
      if ({obs, op_code} !== {E_OFF, 5'd0}) begin
        miscompares++;
        $display("FAIL clr_idle cyc%0d got %h want %h", i, {obs, op_code}, {E_OFF, 5'd0});
      end
    end
    Start = 1'b1;
    @(posedge Clock); #2;
    vectors++;
    if ({obs, op_code} !== {E_T0, 5'd0}) begin
      miscompares++;
      $display("FAIL clr_resume got %h want %h", {obs, op_code}, {E_T0, 5'd0});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_fetch_stall();
    test_muldiv();
    test_two_op();
    test_nop();
    test_illegal();
    test_stop_halt();
    test_clear_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
